// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the request type encodings, the memory bus field widths and the
// responder FSM state enum. Imported by the interface, the storage array
// and the top-level responder.
package dmem_responder_pkg;

  // Field widths of the memreq/memresp bus
  localparam int MEMREQ_TYPE_W = 1;
  localparam int MEMREQ_ADDR_W = 32;
  localparam int MEMREQ_DATA_W = 32;

  // Request type encodings
  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a requester (processor side) and the
// data-memory responder.
// Request channel : memreq_val, memreq_rdy, memreq_type, memreq_addr,
//                   memreq_wdata
// Response channel: memresp_val, memresp_rdy, memresp_type, memresp_data
// Modports: master (requester) and slave (responder).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                     memreq_val;
  logic                     memreq_rdy;
  logic [MEMREQ_TYPE_W-1:0] memreq_type;
  logic [MEMREQ_ADDR_W-1:0] memreq_addr;
  logic [MEMREQ_DATA_W-1:0] memreq_wdata;

  logic                     memresp_val;
  logic                     memresp_rdy;
  logic [MEMREQ_TYPE_W-1:0] memresp_type;
  logic [MEMREQ_DATA_W-1:0] memresp_data;

  modport master (
    output memreq_val, memreq_type, memreq_addr, memreq_wdata, memresp_rdy,
    input  memreq_rdy, memresp_val, memresp_type, memresp_data
  );

  modport slave (
    input  memreq_val, memreq_type, memreq_addr, memreq_wdata, memresp_rdy,
    output memreq_rdy, memresp_val, memresp_type, memresp_data
  );

endinterface

// File: rtl/dmem_responder_mem_array.sv
// Word storage for the data-memory responder.
// NUM_WORDS x 32-bit array with one synchronous write port and one
// synchronous read port. Contents are never reset.
// Ports:
//   clk     - clock
//   wr_en   - write enable, wr_idx/wr_data written on the rising edge
//   rd_en   - read enable, rd_data loaded from mem[rd_idx] on the rising edge
//   rd_data - registered read data, holds its value while rd_en is low
module dmem_responder_mem_array
  import dmem_responder_pkg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [MEMREQ_DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [MEMREQ_DATA_W-1:0] rd_data
);

  logic [MEMREQ_DATA_W-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the processor data-memory request bus.
// Accepts one read or write at a time, waits LATENCY cycles, then presents
// a response that is held until the consumer accepts it.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - asynchronous active-low reset
//   dmem  - slave side of the memreq/memresp bus
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_responder_if.slave dmem
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic                     req_type_q;
  logic [IDX_W-1:0]         req_idx_q;
  logic [MEMREQ_DATA_W-1:0] req_wdata_q;
  logic                     resp_is_read;

  logic                     req_rdy;
  logic                     req_fire;
  logic                     resp_fire;
  logic [IDX_W-1:0]         in_idx;

  logic                     acc_now;
  logic                     acc_type;
  logic [IDX_W-1:0]         acc_idx;
  logic [MEMREQ_DATA_W-1:0] acc_wdata;
  logic [MEMREQ_DATA_W-1:0] rd_data;

  // Only the word index field of the address matters; the byte offset and
  // the bits above the index are dropped so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dmem.memreq_addr[MEMREQ_ADDR_W-1:2+IDX_W],
                              dmem.memreq_addr[1:0]};
  assign in_idx = dmem.memreq_addr[2 +: IDX_W];

  // Ready is gated by rst so it reads low for the whole reset window. In
  // RESP a new request can only be taken together with the response.
  always_comb begin
    req_rdy = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    req_rdy = 1'b1;
        RESP:    req_rdy = dmem.memresp_rdy;
        default: req_rdy = 1'b0;
      endcase
    end
  end

  assign req_fire  = dmem.memreq_val & req_rdy;
  assign resp_fire = (state == RESP) & dmem.memresp_rdy;

  // The array is accessed on the edge that enters RESP. With a one-cycle
  // latency that is the accept edge itself, so the incoming request is used
  // directly; otherwise the latched request is used on the last WAIT edge.
  always_comb begin
    acc_now   = 1'b0;
    acc_type  = req_type_q;
    acc_idx   = req_idx_q;
    acc_wdata = req_wdata_q;
    if (LATENCY == 1) begin
      if (req_fire) begin
        acc_now   = 1'b1;
        acc_type  = dmem.memreq_type;
        acc_idx   = in_idx;
        acc_wdata = dmem.memreq_wdata;
      end
    end else if ((state == WAIT) && (count == CNT_LAST)) begin
      acc_now = 1'b1;
    end
  end

  // Control FSM plus the request latch. A request can only fire from IDLE
  // or alongside a response fire in RESP, so both paths share the latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= '0;
      req_type_q   <= MEMREQ_READ;
      req_idx_q    <= '0;
      req_wdata_q  <= '0;
      resp_is_read <= 1'b0;
    end else begin
      if (req_fire) begin
        req_type_q  <= dmem.memreq_type;
        req_idx_q   <= in_idx;
        req_wdata_q <= dmem.memreq_wdata;
        if (LATENCY == 1) begin
          state <= RESP;
        end else begin
          count <= CNT_LOAD;
          state <= WAIT;
        end
      end else begin
        case (state)
          IDLE: state <= IDLE;
          WAIT: begin
            count <= count - CNT_W'(1);
            if (count == CNT_LAST) begin
              state <= RESP;
            end
          end
          RESP: begin
            if (resp_fire) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (acc_now) begin
        resp_is_read <= (acc_type == MEMREQ_READ);
      end
    end
  end

  dmem_responder_mem_array #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (acc_now & (acc_type == MEMREQ_WRITE)),
    .wr_idx  (acc_idx),
    .wr_data (acc_wdata),
    .rd_en   (acc_now & (acc_type == MEMREQ_READ)),
    .rd_idx  (acc_idx),
    .rd_data (rd_data)
  );

  // Write responses carry zero data; the flag is reset so the data output
  // is zero out of reset even though the array itself is not.
  assign dmem.memreq_rdy    = req_rdy;
  assign dmem.memresp_val   = (state == RESP);
  assign dmem.memresp_type  = req_type_q;
  assign dmem.memresp_data  = resp_is_read ? rd_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder. Two instances are built, one with
// LATENCY=1 and one with LATENCY=3; a select signal steers the shared
// stimulus to one of them at a time.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_val;
  logic        req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_rdy;

  int checks;
  int fails;

  dmem_responder_if if1 ();
  dmem_responder_if if3 ();

  assign if1.memreq_val   = req_val & ~sel;
  assign if1.memreq_type  = req_type;
  assign if1.memreq_addr  = req_addr;
  assign if1.memreq_wdata = req_wdata;
  assign if1.memresp_rdy  = sel ? 1'b1 : resp_rdy;

  assign if3.memreq_val   = req_val & sel;
  assign if3.memreq_type  = req_type;
  assign if3.memreq_addr  = req_addr;
  assign if3.memreq_wdata = req_wdata;
  assign if3.memresp_rdy  = sel ? resp_rdy : 1'b1;

  logic        obs_req_rdy;
  logic        obs_resp_val;
  logic        obs_resp_type;
  logic [31:0] obs_resp_data;

  assign obs_req_rdy   = sel ? if3.memreq_rdy   : if1.memreq_rdy;
  assign obs_resp_val  = sel ? if3.memresp_val  : if1.memresp_val;
  assign obs_resp_type = sel ? if3.memresp_type : if1.memresp_type;
  assign obs_resp_data = sel ? if3.memresp_data : if1.memresp_data;

  dmem_responder #(.NUM_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .dmem (if1)
  );

  dmem_responder #(.NUM_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk  (clk),
    .rst  (rst),
    .dmem (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request with the response accepted immediately; returns the
  // response fields and the number of cycles from accept to response valid
  // (-1 if no response appeared within the bound).
  task automatic transact(input logic t, input logic [31:0] a,
                          input logic [31:0] wd, output logic rt,
                          output logic [31:0] rd, output int lat);
    int guard;
    req_val   = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_wdata = wd;
    resp_rdy  = 1'b1;
    guard = 0;
    while (!obs_req_rdy && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    req_val = 1'b0;
    lat = 1;
    rt  = 1'b0;
    rd  = '0;
    while (!obs_resp_val && lat < 20) begin
      tick();
      lat++;
    end
    if (!obs_resp_val) begin
      lat = -1;
    end else begin
      rt = obs_resp_type;
      rd = obs_resp_data;
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (if1.memreq_rdy !== 1'b0) begin fails++; $display("[TB] FAIL reset_rdy1: got %b expected 0", if1.memreq_rdy); end
    checks++; if (if3.memreq_rdy !== 1'b0) begin fails++; $display("[TB] FAIL reset_rdy3: got %b expected 0", if3.memreq_rdy); end
    checks++; if (if1.memresp_val !== 1'b0) begin fails++; $display("[TB] FAIL reset_val: got %b expected 0", if1.memresp_val); end
    checks++; if (if1.memresp_type !== 1'b0) begin fails++; $display("[TB] FAIL reset_type: got %b expected 0", if1.memresp_type); end
    checks++; if (if1.memresp_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", if1.memresp_data); end
    checks++; if (if3.memresp_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_data3: got %h expected 0", if3.memresp_data); end
    rst = 1'b1;
    tick();
    checks++; if (if1.memreq_rdy !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_rdy1: got %b expected 1", if1.memreq_rdy); end
    checks++; if (if3.memreq_rdy !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_rdy3: got %b expected 1", if3.memreq_rdy); end
  endtask

  task automatic test_latency1();
    logic rt; logic [31:0] rd; int lat;
    sel = 1'b0; #1;
    transact(MEMREQ_WRITE, 32'h10, 32'hDEADBEEF, rt, rd, lat);
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL l1_wr_lat: got %0d expected 1", lat); end
    checks++; if (rt !== 1'b1) begin fails++; $display("[TB] FAIL l1_wr_type: got %b expected 1", rt); end
    checks++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL l1_wr_data: got %h expected 0", rd); end
    transact(MEMREQ_READ, 32'h10, 32'h0, rt, rd, lat);
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL l1_rd_lat: got %0d expected 1", lat); end
    checks++; if (rt !== 1'b0) begin fails++; $display("[TB] FAIL l1_rd_type: got %b expected 0", rt); end
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL l1_rd_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_latency3_backpressure();
    logic rt; logic [31:0] rd; int lat;
    sel = 1'b1; #1;
    transact(MEMREQ_WRITE, 32'h20, 32'h1234, rt, rd, lat);
    checks++; if (lat !== 3) begin fails++; $display("[TB] FAIL l3_wr_lat: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL l3_wr_data: got %h expected 0", rd); end
    req_val = 1'b1; req_type = MEMREQ_READ; req_addr = 32'h20; resp_rdy = 1'b1; #1;
    checks++; if (obs_req_rdy !== 1'b1) begin fails++; $display("[TB] FAIL l3_accept_rdy: got %b expected 1", obs_req_rdy); end
    tick();
    req_val = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      checks++; if (obs_resp_val !== 1'b0) begin fails++; $display("[TB] FAIL l3_wait_val c%0d: got %b expected 0", c, obs_resp_val); end
      checks++; if (obs_req_rdy !== 1'b0) begin fails++; $display("[TB] FAIL l3_wait_rdy c%0d: got %b expected 0", c, obs_req_rdy); end
      tick();
    end
    resp_rdy = 1'b0; #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (obs_resp_val !== 1'b1) begin fails++; $display("[TB] FAIL bp_val c%0d: got %b expected 1", c, obs_resp_val); end
      checks++; if (obs_resp_data !== 32'h1234) begin fails++; $display("[TB] FAIL bp_data c%0d: got %h expected 1234", c, obs_resp_data); end
      checks++; if (obs_req_rdy !== 1'b0) begin fails++; $display("[TB] FAIL bp_rdy c%0d: got %b expected 0", c, obs_req_rdy); end
      tick();
    end
    resp_rdy = 1'b1; #1;
    checks++; if (obs_req_rdy !== 1'b1) begin fails++; $display("[TB] FAIL bp_release_rdy: got %b expected 1", obs_req_rdy); end
    tick();
    checks++; if (obs_resp_val !== 1'b0) begin fails++; $display("[TB] FAIL bp_drained_val: got %b expected 0", obs_resp_val); end
    transact(MEMREQ_READ, 32'h20, 32'h0, rt, rd, lat);
    checks++; if (lat !== 3) begin fails++; $display("[TB] FAIL bp_next_lat: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h1234) begin fails++; $display("[TB] FAIL bp_next_data: got %h expected 1234", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [3];
    logic        exp_type [3];
    exp_data[0] = 32'h0; exp_data[1] = 32'h7; exp_data[2] = 32'h7;
    exp_type[0] = 1'b1;  exp_type[1] = 1'b0;  exp_type[2] = 1'b0;
    sel = 1'b0; resp_rdy = 1'b1;
    req_val = 1'b1; req_type = MEMREQ_WRITE; req_addr = 32'h4; req_wdata = 32'h7; #1;
    checks++; if (obs_req_rdy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_first_rdy: got %b expected 1", obs_req_rdy); end
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin req_type = MEMREQ_READ; req_addr = 32'h4; end
      else if (c == 1) begin req_type = MEMREQ_READ; req_addr = 32'h5; end
      else req_val = 1'b0;
      #1;
      checks++; if (obs_resp_val !== 1'b1) begin fails++; $display("[TB] FAIL b2b_val c%0d: got %b expected 1", c, obs_resp_val); end
      checks++; if (obs_resp_type !== exp_type[c]) begin fails++; $display("[TB] FAIL b2b_type c%0d: got %b expected %b", c, obs_resp_type, exp_type[c]); end
      checks++; if (obs_resp_data !== exp_data[c]) begin fails++; $display("[TB] FAIL b2b_data c%0d: got %h expected %h", c, obs_resp_data, exp_data[c]); end
      if (c < 2) begin
        checks++; if (obs_req_rdy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_rdy c%0d: got %b expected 1", c, obs_req_rdy); end
      end
      tick();
    end
    checks++; if (obs_resp_val !== 1'b0) begin fails++; $display("[TB] FAIL b2b_end_val: got %b expected 0", obs_resp_val); end
  endtask

  task automatic test_alias();
    logic rt; logic [31:0] rd; int lat;
    sel = 1'b0; #1;
    transact(MEMREQ_WRITE, 32'h400, 32'hA5, rt, rd, lat);
    transact(MEMREQ_READ, 32'h0, 32'h0, rt, rd, lat);
    checks++; if (rd !== 32'hA5) begin fails++; $display("[TB] FAIL alias_rd0: got %h expected a5", rd); end
    transact(MEMREQ_READ, 32'h3, 32'h0, rt, rd, lat);
    checks++; if (rd !== 32'hA5) begin fails++; $display("[TB] FAIL alias_rd3: got %h expected a5", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic rt; logic [31:0] rd; int lat;
    sel = 1'b1; #1;
    transact(MEMREQ_WRITE, 32'h8, 32'h55, rt, rd, lat);
    req_val = 1'b1; req_type = MEMREQ_WRITE; req_addr = 32'h8; req_wdata = 32'h9; resp_rdy = 1'b1;
    tick();
    req_val = 1'b0;
    tick();
    rst = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (obs_req_rdy !== 1'b0) begin fails++; $display("[TB] FAIL rmw_rdy c%0d: got %b expected 0", c, obs_req_rdy); end
      checks++; if (obs_resp_val !== 1'b0) begin fails++; $display("[TB] FAIL rmw_val c%0d: got %b expected 0", c, obs_resp_val); end
      tick();
    end
    rst = 1'b1;
    tick();
    checks++; if (obs_req_rdy !== 1'b1) begin fails++; $display("[TB] FAIL rmw_release_rdy: got %b expected 1", obs_req_rdy); end
    checks++; if (obs_resp_val !== 1'b0) begin fails++; $display("[TB] FAIL rmw_release_val: got %b expected 0", obs_resp_val); end
    transact(MEMREQ_READ, 32'h8, 32'h0, rt, rd, lat);
    checks++; if (lat !== 3) begin fails++; $display("[TB] FAIL rmw_rd_lat: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h55) begin fails++; $display("[TB] FAIL rmw_rd_data: got %h expected 55", rd); end
  endtask

  initial begin
    checks = 0; fails = 0;
    rst = 1'b0; sel = 1'b0; req_val = 1'b0; req_type = 1'b0;
    req_addr = '0; req_wdata = '0; resp_rdy = 1'b1;
    $display("[TB] starting dmem_responder bench");
    test_reset();
    test_latency1();
    test_latency3_backpressure();
    test_back_to_back();
    test_alias();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
